// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 single-line writer.
// LCD_INIT_EN selects the power-up/init command sequence.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWR,
        ST_INIT,
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } lcd_state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } strobe_phase_e;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE1    = 8'h80;

    localparam int NUM_COLS = 16;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Column 0 lives in the top byte of the window.
    function automatic logic [7:0] col_byte(
        input logic [127:0] w,
        input logic [3:0]   col
    );
        return w[{~col, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] c;
        c = CMD_FUNC_SET;
        case (idx)
            2'd1:    c = CMD_DISP_ON;
            2'd2:    c = CMD_ENTRY;
            2'd3:    c = CMD_CLEAR;
            default: c = CMD_FUNC_SET;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_line_writer_strobe.sv
// HD44780 byte-write sequencer: SETUP (E low), PULSE (E high), HOLD (E low).
// ready_o is high when idle or in the last HOLD cycle, so writes chain back to back.
module lcd_write_strobe
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC    = 4,
    parameter int E_HIGH_CYC   = 12,
    parameter int WAIT_CYC     = 2000,
    parameter int CLR_WAIT_CYC = 80000,
    parameter int CNT_W        = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       rs_i,
    input  logic [7:0] byte_i,
    input  logic       long_wait_i,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [7:0] lcd_db,
    output logic       ready_o
);

    strobe_phase_e    phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic [7:0]       db_q, db_d;
    logic             e_q, e_d;
    logic             long_q, long_d;
    logic             hold_last;

    always_comb begin
        hold_last = long_q ? (cnt_q == CNT_W'(CLR_WAIT_CYC - 1))
                           : (cnt_q == CNT_W'(WAIT_CYC - 1));
        ready_o = (phase_q == PH_IDLE) || ((phase_q == PH_HOLD) && hold_last);
        phase_d = phase_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        db_d    = db_q;
        e_d     = e_q;
        long_d  = long_q;
        if (ready_o && start_i) begin
            phase_d = PH_SETUP;
            cnt_d   = '0;
            rs_d    = rs_i;
            db_d    = byte_i;
            long_d  = long_wait_i;
            e_d     = 1'b0;
        end else begin
            unique case (phase_q)
                PH_SETUP: begin
                    if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                        phase_d = PH_PULSE;
                        cnt_d   = '0;
                        e_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PH_PULSE: begin
                    if (cnt_q == CNT_W'(E_HIGH_CYC - 1)) begin
                        phase_d = PH_HOLD;
                        cnt_d   = '0;
                        e_d     = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PH_HOLD: begin
                    if (hold_last) begin
                        phase_d = PH_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    phase_d = PH_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            db_q    <= 8'h00;
            e_q     <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            e_q     <= e_d;
            long_q  <= long_d;
        end
    end

    assign lcd_rs = rs_q;
    assign lcd_e  = e_q;
    assign lcd_db = db_q;

endmodule

// File: rtl/lcd_line_writer.sv
// Writes a 16-char window to HD44780 line 1 (8-bit bus), latest request wins.
// Define LCD_INIT_EN to add the power-up delay and init command sequence.
module lcd_line_writer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC    = 4,
    parameter int E_HIGH_CYC   = 12,
    parameter int WAIT_CYC     = 2000,
    parameter int CLR_WAIT_CYC = 80000,
    parameter int PWR_CYC      = 800000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] win_i,
    input  logic         win_vld_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic [7:0]   lcd_db
);

    localparam int MAX_CYC = max_i(max_i(PWR_CYC, CLR_WAIT_CYC),
                                   max_i(WAIT_CYC, max_i(SETUP_CYC, E_HIGH_CYC)));
    localparam int CNT_W = $clog2(MAX_CYC) + 1;

    lcd_state_e     state_q, state_d;
    logic [127:0]   snap_q, snap_d;
    logic [127:0]   pbuf_q, pbuf_d;
    logic           pend_q, pend_d;
    logic [3:0]     col_q, col_d;
    logic           done_q, done_d;
`ifdef LCD_INIT_EN
    logic [CNT_W-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [1:0]       init_idx_q, init_idx_d;
`endif

    logic       wr_start;
    logic       wr_rs;
    logic [7:0] wr_byte;
    logic       wr_long;
    logic       wr_ready;

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        pbuf_d   = pbuf_q;
        pend_d   = pend_q;
        col_d    = col_q;
        done_d   = 1'b0;
        wr_start = 1'b0;
        wr_rs    = 1'b0;
        wr_byte  = CMD_LINE1;
`ifdef LCD_INIT_EN
        pwr_cnt_d  = pwr_cnt_q;
        init_idx_d = init_idx_q;
`endif
        if (win_vld_i && (state_q != ST_IDLE)) begin
            pend_d = 1'b1;
            pbuf_d = win_i;
        end
        unique case (state_q)
`ifdef LCD_INIT_EN
            ST_PWR: begin
                if (pwr_cnt_q == CNT_W'(PWR_CYC - 1)) begin
                    wr_start   = 1'b1;
                    wr_byte    = init_cmd(2'd0);
                    init_idx_d = 2'd0;
                    state_d    = ST_INIT;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 1'b1;
                end
            end
            ST_INIT: begin
                if (wr_ready) begin
                    if (init_idx_q == 2'd3) begin
                        state_d = ST_IDLE;
                    end else begin
                        wr_start   = 1'b1;
                        wr_byte    = init_cmd(init_idx_q + 2'd1);
                        init_idx_d = init_idx_q + 2'd1;
                    end
                end
            end
`endif
            ST_IDLE: begin
                // Address write is launched here so its pins are valid on ADDR entry.
                if (win_vld_i || pend_q) begin
                    snap_d   = win_vld_i ? win_i : pbuf_q;
                    pend_d   = 1'b0;
                    col_d    = 4'd0;
                    wr_start = 1'b1;
                    wr_byte  = CMD_LINE1;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (wr_ready) begin
                    wr_start = 1'b1;
                    wr_rs    = 1'b1;
                    wr_byte  = col_byte(snap_q, col_q);
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (wr_ready) begin
                    if (col_q == 4'(NUM_COLS - 1)) begin
                        col_d   = 4'd0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        wr_start = 1'b1;
                        wr_rs    = 1'b1;
                        wr_byte  = col_byte(snap_q, col_q + 4'd1);
                        col_d    = col_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        wr_long = !wr_rs && (wr_byte == CMD_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef LCD_INIT_EN
            state_q    <= ST_PWR;
            pwr_cnt_q  <= '0;
            init_idx_q <= 2'd0;
`else
            state_q    <= ST_IDLE;
`endif
            snap_q <= '0;
            pbuf_q <= '0;
            pend_q <= 1'b0;
            col_q  <= 4'd0;
            done_q <= 1'b0;
        end else begin
`ifdef LCD_INIT_EN
            pwr_cnt_q  <= pwr_cnt_d;
            init_idx_q <= init_idx_d;
`endif
            state_q <= state_d;
            snap_q  <= snap_d;
            pbuf_q  <= pbuf_d;
            pend_q  <= pend_d;
            col_q   <= col_d;
            done_q  <= done_d;
        end
    end

    lcd_write_strobe #(
        .SETUP_CYC    (SETUP_CYC),
        .E_HIGH_CYC   (E_HIGH_CYC),
        .WAIT_CYC     (WAIT_CYC),
        .CLR_WAIT_CYC (CLR_WAIT_CYC),
        .CNT_W        (CNT_W)
    ) u_strobe (
        .clk         (clk),
        .rst         (rst),
        .start_i     (wr_start),
        .rs_i        (wr_rs),
        .byte_i      (wr_byte),
        .long_wait_i (wr_long),
        .lcd_rs      (lcd_rs),
        .lcd_e       (lcd_e),
        .lcd_db      (lcd_db),
        .ready_o     (wr_ready)
    );

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = done_q;
    assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_line_writer.sv
// Scoreboard bench for lcd_line_writer: reference model queues expected bus writes.
// and done cycles; a negedge monitor checks the LCD pins and done_o against them.
module tb_lcd_line_writer;

    localparam int SETUP = 1;
    localparam int EHIGH = 2;
    localparam int WAITC = 3;
    localparam int CLRW  = 5;
    localparam int PWRC  = 4;
    localparam int PER   = SETUP + EHIGH + WAITC;
`ifdef LCD_INIT_EN
    localparam int INIT_CYC = PWRC + 3 * PER + (SETUP + EHIGH + CLRW);
    localparam bit BUSY_RST = 1'b1;
`else
    localparam int INIT_CYC = 0;
    localparam bit BUSY_RST = 1'b0;
`endif

    typedef struct packed {
        logic       rs;
        logic [7:0] db;
        logic       lng;
    } wr_t;

    logic         clk;
    logic         rst;
    logic [127:0] win_i;
    logic         win_vld_i;
    logic         busy_o;
    logic         done_o;
    logic         lcd_rs;
    logic         lcd_rw;
    logic         lcd_e;
    logic [7:0]   lcd_db;

    lcd_line_writer #(
        .SETUP_CYC    (SETUP),
        .E_HIGH_CYC   (EHIGH),
        .WAIT_CYC     (WAITC),
        .CLR_WAIT_CYC (CLRW),
        .PWR_CYC      (PWRC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .win_i     (win_i),
        .win_vld_i (win_vld_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .lcd_db    (lcd_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // ---------------- reference model ----------------
    int   cyc = 0;
    int   m_end = 0;
    bit   m_pend = 0;
    logic [127:0] m_pbuf;
    wr_t  wq[$];
    int   dq[$];

    // A refresh is one address write plus 16 character writes, one per period.
    task automatic push_refresh(input logic [127:0] v, input int n);
        logic [127:0] t;
        t = v;
        wq.push_back('{rs: 1'b0, db: 8'h80, lng: 1'b0});
        for (int c = 0; c < 16; c++) begin
            wq.push_back('{rs: 1'b1, db: t[127 - 8 * c -: 8], lng: 1'b0});
        end
        m_end = n + 1 + 17 * PER;
        dq.push_back(m_end);
    endtask

    bit need_init = 0;
    always @(posedge clk) begin
        if (rst) begin
            wq.delete();
            dq.delete();
            m_pend    = 0;
            m_end     = cyc + 1 + INIT_CYC;
            need_init = 1;
        end else begin
            if (need_init) begin
`ifdef LCD_INIT_EN
                wq.push_back('{rs: 1'b0, db: 8'h38, lng: 1'b0});
                wq.push_back('{rs: 1'b0, db: 8'h0C, lng: 1'b0});
                wq.push_back('{rs: 1'b0, db: 8'h06, lng: 1'b0});
                wq.push_back('{rs: 1'b0, db: 8'h01, lng: 1'b1});
`endif
                need_init = 0;
            end
            if (cyc >= m_end) begin
                if (win_vld_i) begin
                    push_refresh(win_i, cyc);
                    m_pend = 0;
                end else if (m_pend) begin
                    push_refresh(m_pbuf, cyc);
                    m_pend = 0;
                end
            end else if (win_vld_i) begin
                m_pend = 1;
                m_pbuf = win_i;
            end
        end
        cyc = cyc + 1;
    end

    // ---------------- monitor ----------------
    int   ehi, lowc, prev_h, cur_h, dexp;
    bit   have_write, hold_bad, is_clear, prev_clear;
    logic cur_rs, rs_prev, e_prev;
    logic [7:0] cur_db, db_prev;

    always @(negedge clk) begin
        wr_t ex;
        if (rst) begin
            e_prev     = 1'b0;
            ehi        = 0;
            lowc       = 0;
            have_write = 0;
            hold_bad   = 0;
        end else begin
            if (lcd_e && !e_prev) begin
                if (have_write)
                    chk(lowc >= prev_h + SETUP, "hold_gap", lowc, prev_h + SETUP);
                have_write = 0;
                cur_h      = WAITC;
                is_clear   = 0;
                if (wq.size() == 0) begin
                    chk(1'b0, "unexpected_write", {23'b0, lcd_rs, lcd_db}, 0);
                end else begin
                    ex = wq.pop_front();
                    chk(lcd_rs === ex.rs && lcd_db === ex.db, "write_byte",
                        {23'b0, lcd_rs, lcd_db}, {23'b0, ex.rs, ex.db});
                    if (ex.lng) cur_h = CLRW;
                    is_clear = ex.lng;
                end
                chk(lcd_rs === rs_prev && lcd_db === db_prev && lcd_rw === 1'b0,
                    "setup_stable", {23'b0, lcd_rs, lcd_db}, {23'b0, rs_prev, db_prev});
                cur_rs = lcd_rs;
                cur_db = lcd_db;
                ehi    = 1;
            end else if (lcd_e) begin
                ehi++;
                if (lcd_rs !== cur_rs || lcd_db !== cur_db || lcd_rw !== 1'b0) hold_bad = 1;
            end else if (e_prev) begin
                chk(ehi == EHIGH, "e_width", ehi, EHIGH);
                have_write = 1;
                prev_h     = cur_h;
                prev_clear = is_clear;
                lowc       = 1;
            end else if (have_write) begin
                lowc++;
            end
            if (!lcd_e && have_write) begin
                if (lowc <= prev_h &&
                    (lcd_rs !== cur_rs || lcd_db !== cur_db || lcd_rw !== 1'b0))
                    hold_bad = 1;
                if (lowc == prev_h) begin
                    chk(!hold_bad, "rsdb_stable", hold_bad, 0);
                    hold_bad = 0;
                end
`ifdef LCD_INIT_EN
                if (prev_clear && lowc == prev_h)
                    chk(busy_o === 1'b1, "clr_hold_busy", busy_o, 1);
                if (prev_clear && lowc == prev_h + 1)
                    chk(busy_o === 1'b0, "init_busy_fall", busy_o, 0);
`endif
            end
            if (done_o === 1'b1) begin
                if (dq.size() == 0) begin
                    chk(1'b0, "unexpected_done", cyc, 0);
                end else begin
                    dexp = dq.pop_front();
                    chk(cyc == dexp, "done_cycle", cyc, dexp);
                end
            end
        end
        e_prev  = lcd_e;
        rs_prev = lcd_rs;
        db_prev = lcd_db;
    end

    // ---------------- stimulus ----------------
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    int last_n;

    task automatic pulse(input logic [127:0] v);
        @(negedge clk);
        win_i     = v;
        win_vld_i = 1'b1;
        last_n    = cyc;
        @(negedge clk);
        win_vld_i = 1'b0;
        win_i     = rnd128();
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 6000 && !ok; i++) begin
            @(negedge clk);
            win_i = rnd128();
            if (wq.size() == 0 && dq.size() == 0 && !m_pend && cyc > m_end + 1) ok = 1;
        end
        if (!ok) chk(1'b0, "timeout", cyc, m_end);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "simulation did not terminate");
    end

    initial begin
        int n;
        rst       = 1'b1;
        win_i     = '0;
        win_vld_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(lcd_e === 1'b0, "rst_e", lcd_e, 0);
        chk(lcd_rs === 1'b0, "rst_rs", lcd_rs, 0);
        chk(lcd_db === 8'h00, "rst_db", lcd_db, 0);
        chk(done_o === 1'b0, "rst_done", done_o, 0);
        chk(lcd_rw === 1'b0, "rst_rw", lcd_rw, 0);
        chk(busy_o === BUSY_RST, "rst_busy", busy_o, BUSY_RST);
        @(negedge clk);
        rst = 1'b0;
        wait_idle();

        // Directed name string
        pulse("   Phan Minh Nha");
        wait_idle();

        // Three requests during a refresh: only the last one is written
        pulse(rnd128());
        repeat (10) @(negedge clk);
        pulse(rnd128());
        repeat (20) @(negedge clk);
        pulse(rnd128());
        repeat (20) @(negedge clk);
        pulse(rnd128());
        wait_idle();

        // Request coincident with done_o
        pulse(rnd128());
        n = last_n;
        while (cyc < n + 1 + 17 * PER - 1) @(negedge clk);
        pulse(rnd128());
        wait_idle();

        // Random traffic with window changing every cycle
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            win_i     = rnd128();
            win_vld_i = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        win_vld_i = 1'b0;
        wait_idle();

        // Reset on the 40th cycle of a refresh
        pulse(rnd128());
        n = last_n;
        while (cyc < n + 39) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk(lcd_e === 1'b0, "midrst_e", lcd_e, 0);
        chk(busy_o === BUSY_RST, "midrst_busy", busy_o, BUSY_RST);
        chk(done_o === 1'b0, "midrst_done", done_o, 0);
        rst = 1'b0;
        wait_idle();

        pulse(rnd128());
        wait_idle();

        chk(wq.size() == 0, "leftover_writes", wq.size(), 0);
        chk(dq.size() == 0, "leftover_done", dq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
